// File: rtl/move_sequencer_pkg.sv
// Shared definitions for the move sequencer: move codes, FSM states and error bits.
package move_sequencer_pkg;

    typedef enum logic [3:0] {
        MOVE_R    = 4'd2,
        MOVE_RI   = 4'd3,
        MOVE_L    = 4'd4,
        MOVE_LI   = 4'd5,
        MOVE_U    = 4'd6,
        MOVE_UI   = 4'd7,
        MOVE_F    = 4'd8,
        MOVE_FI   = 4'd9,
        MOVE_B    = 4'd10,
        MOVE_BI   = 4'd11,
        MOVE_D    = 4'd12,
        MOVE_DI   = 4'd13,
        MOVE_NULL = 4'd15
    } move_code_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_START,
        ST_WAIT_BUSY,
        ST_WAIT_DONE,
        ST_SETTLE
    } state_t;

    localparam int ERR_OVERFLOW = 0;
    localparam int ERR_TIMEOUT  = 1;

    function automatic logic is_valid_move(input logic [3:0] code);
        return (code >= 4'(MOVE_R)) && (code <= 4'(MOVE_DI));
    endfunction

endpackage

// File: rtl/move_sequencer_if.sv
// Bundle of the move sequencer's data, control and status signals.
interface move_sequencer_if #(
    parameter int DEPTH = 64
) ();
    localparam int AW = $clog2(DEPTH);

    logic [3:0]  move_in;
    logic        move_wr;
    logic        run;
    logic        abort;
    logic        move_done;
    logic [3:0]  next_move;
    logic        move_start;
    logic [AW:0] fifo_count;
    logic        fifo_full;
    logic        busy;
    logic        seq_done;
    logic [7:0]  moves_executed;
    logic [1:0]  error;

    modport slave (
        input  move_in, move_wr, run, abort, move_done,
        output next_move, move_start, fifo_count, fifo_full, busy, seq_done,
               moves_executed, error
    );

    modport master (
        output move_in, move_wr, run, abort, move_done,
        input  next_move, move_start, fifo_count, fifo_full, busy, seq_done,
               moves_executed, error
    );
endinterface

// File: rtl/move_fifo.sv
// Synchronous FIFO with occupancy count, flush and a write-while-full overflow strobe.
module move_fifo #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic             flush,
    output logic [WIDTH-1:0] rd_data,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty,
    output logic             overflow
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             do_wr;
    logic             do_rd;

    assign full     = (count_reg == (AW+1)'(DEPTH));
    assign empty    = (count_reg == '0);
    assign count    = count_reg;
    assign rd_data  = mem[rd_ptr_reg];
    // A flush wins over everything else in its cycle, including the write.
    assign do_wr    = wr_en && !full && !flush;
    assign do_rd    = rd_en && !empty && !flush;
    assign overflow = wr_en && full && !flush;

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_wr) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_rd) rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end
endmodule

// File: rtl/move_sequencer.sv
// Buffers solver moves and issues them one at a time to the stepper stage with a settle pause.
module move_sequencer
    import move_sequencer_pkg::*;
#(
    parameter int DEPTH         = 64,
    parameter int SETTLE_CYCLES = 2_500_000,
    parameter int ACK_TIMEOUT   = 4096
) (
    input logic             clk,
    input logic             rst,
    move_sequencer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    state_t        state_reg,      state_next;
    logic [3:0]    next_move_reg,  next_move_next;
    logic [7:0]    moves_reg,      moves_next;
    logic [1:0]    error_reg,      error_next;
    logic [SW-1:0] settle_reg,     settle_next;
    logic [TW-1:0] timeout_reg,    timeout_next;
    logic          abort_seen_reg, abort_seen_next;

    logic          fifo_rd;
    logic [3:0]    fifo_data;
    logic [AW:0]   fifo_count;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_overflow;
    logic          move_start;
    logic          seq_done;

    move_fifo #(.DEPTH(DEPTH), .WIDTH(4)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (bus.move_wr),
        .wr_data  (bus.move_in),
        .rd_en    (fifo_rd),
        .flush    (bus.abort),
        .rd_data  (fifo_data),
        .count    (fifo_count),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .overflow (fifo_overflow)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            next_move_reg  <= 4'(MOVE_NULL);
            moves_reg      <= '0;
            error_reg      <= '0;
            settle_reg     <= '0;
            timeout_reg    <= '0;
            abort_seen_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            next_move_reg  <= next_move_next;
            moves_reg      <= moves_next;
            error_reg      <= error_next;
            settle_reg     <= settle_next;
            timeout_reg    <= timeout_next;
            abort_seen_reg <= abort_seen_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        next_move_next  = next_move_reg;
        moves_next      = moves_reg;
        error_next      = error_reg;
        settle_next     = settle_reg;
        timeout_next    = timeout_reg;
        abort_seen_next = abort_seen_reg | (bus.abort && (state_reg != ST_IDLE));
        fifo_rd         = 1'b0;
        move_start      = 1'b0;
        seq_done        = 1'b0;

        if (fifo_overflow) error_next[ERR_OVERFLOW] = 1'b1;

        case (state_reg)
            ST_IDLE: begin
                if (bus.run && !fifo_empty && !error_reg[ERR_TIMEOUT]) state_next = ST_FETCH;
            end
            ST_FETCH: begin
                if (bus.abort) begin
                    state_next = ST_IDLE;
                end else if (fifo_empty) begin
                    seq_done   = 1'b1;
                    state_next = ST_IDLE;
                end else begin
                    fifo_rd = 1'b1;
                    if (is_valid_move(fifo_data)) begin
                        next_move_next = fifo_data;
                        state_next     = ST_START;
                    end else if (fifo_count <= (AW+1)'(1)) begin
                        // Skipped the last entry: the sequence is exhausted.
                        seq_done   = 1'b1;
                        state_next = ST_IDLE;
                    end
                end
            end
            ST_START: begin
                move_start   = 1'b1;
                if (moves_reg != 8'hFF) moves_next = moves_reg + 8'd1;
                timeout_next = '0;
                state_next   = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (!bus.move_done) begin
                    state_next = ST_WAIT_DONE;
                end else if (timeout_reg == TW'(ACK_TIMEOUT - 1)) begin
                    error_next[ERR_TIMEOUT] = 1'b1;
                    state_next              = ST_IDLE;
                end else begin
                    timeout_next = timeout_reg + 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (bus.move_done) begin
                    settle_next = SW'(SETTLE_CYCLES - 1);
                    state_next  = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (settle_reg == '0) begin
                    if (abort_seen_reg || bus.abort || !bus.run) state_next = ST_IDLE;
                    else                                         state_next = ST_FETCH;
                end else begin
                    settle_next = settle_reg - 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        if (state_next == ST_IDLE) abort_seen_next = 1'b0;
    end

    assign bus.next_move      = next_move_reg;
    assign bus.move_start     = move_start;
    assign bus.fifo_count     = fifo_count;
    assign bus.fifo_full      = fifo_full;
    assign bus.busy           = (state_reg != ST_IDLE);
    assign bus.seq_done       = seq_done;
    assign bus.moves_executed = moves_reg;
    assign bus.error          = error_reg;
endmodule

// File: tb/tb_move_sequencer.sv
// Directed bench for move_sequencer: queue-based reference model compared every cycle plus literal checks.
module tb_move_sequencer;
    localparam int DEPTH  = 64;
    localparam int SETTLE = 100;
    localparam int ACK    = 4096;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    move_sequencer_if #(.DEPTH(DEPTH)) bus ();

    move_sequencer #(
        .DEPTH(DEPTH), .SETTLE_CYCLES(SETTLE), .ACK_TIMEOUT(ACK)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end else begin
            $display("ok   %s = %0d", name, act);
        end
    endtask

    // ---------------- stepper responder ----------------
    bit stuck = 0;
    int rctr  = 0;
    initial bus.move_done = 1'b1;
    always @(posedge clk) begin
        #1;
        if (rst) begin
            bus.move_done = 1'b1;
            rctr = 0;
        end else if (!stuck) begin
            if (bus.move_start) rctr = 1;
            else if (rctr > 0)  rctr++;
            if (rctr == 3) bus.move_done = 1'b0;
            if (rctr == 53) begin
                bus.move_done = 1'b1;
                rctr = 0;
            end
        end
    end

    // ---------------- reference model ----------------
    logic [3:0] q[$];
    bit         m_fetch, m_go, m_ack, m_moving;
    int         m_settle, m_age, m_moves;
    bit         m_abort;
    logic [1:0] m_err;
    logic [3:0] m_next;
    logic [3:0] head;
    bit         was_busy, full_before, to_idle;

    function automatic bit code_ok(input logic [3:0] c);
        return (c >= 4'd2) && (c <= 4'd13);
    endfunction

    function automatic bit m_busy();
        return m_fetch || m_go || m_ack || m_moving || (m_settle > 0);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            m_fetch = 0; m_go = 0; m_ack = 0; m_moving = 0;
            m_settle = 0; m_age = 0; m_moves = 0; m_abort = 0;
            m_err = 2'b00; m_next = 4'd15;
        end else begin
            was_busy    = m_busy();
            full_before = (q.size() == DEPTH);
            to_idle     = 0;
            if (m_fetch) begin
                if (bus.abort || q.size() == 0) begin
                    m_fetch = 0; to_idle = 1;
                end else begin
                    head = q.pop_front();
                    if (code_ok(head)) begin
                        m_next = head; m_fetch = 0; m_go = 1;
                    end else if (q.size() == 0) begin
                        m_fetch = 0; to_idle = 1;
                    end
                end
            end else if (m_go) begin
                m_go = 0; m_ack = 1; m_age = 0;
                if (m_moves < 255) m_moves++;
            end else if (m_ack) begin
                if (!bus.move_done) begin
                    m_ack = 0; m_moving = 1;
                end else begin
                    m_age++;
                    if (m_age == ACK) begin
                        m_ack = 0; m_err[1] = 1'b1; to_idle = 1;
                    end
                end
            end else if (m_moving) begin
                if (bus.move_done) begin
                    m_moving = 0; m_settle = SETTLE;
                end
            end else if (m_settle > 0) begin
                m_settle--;
                if (m_settle == 0) begin
                    if (m_abort || bus.abort || !bus.run) to_idle = 1;
                    else m_fetch = 1;
                end
            end else if (bus.run && q.size() > 0 && !m_err[1]) begin
                m_fetch = 1;
            end
            if (was_busy && bus.abort) m_abort = 1;
            if (to_idle) m_abort = 0;
            if (bus.abort) q.delete();
            else if (bus.move_wr) begin
                if (full_before) m_err[0] = 1'b1;
                else q.push_back(bus.move_in);
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    bit exp_seq;
    always @(negedge clk) begin
        if (!rst) begin
            exp_seq = 0;
            if (m_fetch && !bus.abort) begin
                if (q.size() == 0) exp_seq = 1;
                else if (!code_ok(q[0]) && q.size() == 1) exp_seq = 1;
            end
            checks++;
            if (bus.next_move !== m_next || bus.move_start !== m_go || bus.seq_done !== exp_seq ||
                bus.busy !== m_busy() || bus.fifo_count !== 7'(q.size()) ||
                bus.fifo_full !== (q.size() == DEPTH) || bus.moves_executed !== 8'(m_moves) ||
                bus.error !== m_err) begin
                errors++;
                $display("FAIL cycle %0d outputs: got next=%0d start=%0b seq=%0b busy=%0b cnt=%0d full=%0b moves=%0d err=%0b, expected next=%0d start=%0b seq=%0b busy=%0b cnt=%0d full=%0b moves=%0d err=%0b",
                         cyc, bus.next_move, bus.move_start, bus.seq_done, bus.busy, bus.fifo_count,
                         bus.fifo_full, bus.moves_executed, bus.error, m_next, m_go, exp_seq, m_busy(),
                         q.size(), (q.size() == DEPTH), m_moves, m_err);
            end
        end
    end

    // ---------------- event log ----------------
    typedef struct { int c; int code; } start_t;
    start_t starts[$];
    int     seq_cnt = 0;
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.move_start) starts.push_back('{cyc, int'(bus.next_move)});
            if (bus.seq_done) seq_cnt++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic write(input logic [3:0] code);
        bus.move_in = code;
        bus.move_wr = 1'b1;
        tick();
        bus.move_wr = 1'b0;
    endtask

    task automatic clear_log();
        starts.delete();
        seq_cnt = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        clear_log();
    endtask

    // kind: 0 seq_done seen and idle, 1 idle, 2 move_start, 3 error[1], 4 move_done low
    task automatic wait_for(input int kind, input int budget, input string name);
        bit met;
        for (int i = 0; i < budget; i++) begin
            tick();
            case (kind)
                0:       met = (seq_cnt > 0) && !bus.busy;
                1:       met = !bus.busy;
                2:       met = bus.move_start;
                3:       met = bus.error[1];
                default: met = !bus.move_done;
            endcase
            if (met) return;
        end
        checks++;
        errors++;
        $display("FAIL wait_%s: got timeout after %0d cycles, expected event", name, budget);
    endtask

    int t0, t1;

    initial begin
        bus.move_in = 4'd0; bus.move_wr = 1'b0; bus.run = 1'b0; bus.abort = 1'b0;

        // reset values
        do_reset();
        chk("rst_next_move", bus.next_move, 15);
        chk("rst_busy", bus.busy, 0);
        chk("rst_moves", bus.moves_executed, 0);
        chk("rst_error", bus.error, 0);
        chk("rst_count", bus.fifo_count, 0);

        // three valid moves
        bus.run = 1'b1;
        write(4'd2); write(4'd5); write(4'd12);
        wait_for(0, 2000, "seq3");
        chk("seq3_starts", starts.size(), 3);
        if (starts.size() == 3) begin
            chk("seq3_code0", starts[0].code, 2);
            chk("seq3_code1", starts[1].code, 5);
            chk("seq3_code2", starts[2].code, 12);
            chk("seq3_gap01_ok", int'(starts[1].c - starts[0].c >= SETTLE + 53), 1);
            chk("seq3_gap12_ok", int'(starts[2].c - starts[1].c >= SETTLE + 53), 1);
        end
        chk("seq3_seq_done", seq_cnt, 1);
        chk("seq3_moves", bus.moves_executed, 3);

        // skip codes
        bus.run = 1'b0;
        do_reset();
        bus.run = 1'b1;
        write(4'd0); write(4'd15); write(4'd7);
        wait_for(0, 1000, "skip");
        chk("skip_starts", starts.size(), 1);
        if (starts.size() == 1) chk("skip_code", starts[0].code, 7);
        chk("skip_moves", bus.moves_executed, 1);
        chk("skip_seq_done", seq_cnt, 1);

        // overflow with skip-code fill
        bus.run = 1'b0;
        do_reset();
        for (int i = 0; i < DEPTH; i++) write(4'd1);
        write(4'd6);
        chk("ovf_count", bus.fifo_count, 64);
        chk("ovf_full", bus.fifo_full, 1);
        chk("ovf_error", bus.error, 1);
        bus.run = 1'b1;
        wait_for(0, 500, "ovf_drain");
        chk("ovf_starts", starts.size(), 0);
        chk("ovf_next_move", bus.next_move, 15);
        chk("ovf_count_after", bus.fifo_count, 0);

        // latency, then reset during WAIT_BUSY
        clear_log();
        write(4'd8);
        t0 = cyc;
        wait_for(2, 20, "lat_start");
        chk("lat_cycles", cyc - t0, 2);
        tick();
        chk("pre_rst_moves", bus.moves_executed, 1);
        chk("pre_rst_error", bus.error, 1);
        chk("pre_rst_next", bus.next_move, 8);
        #1 rst = 1'b1;
        #1;
        chk("arst_next_move", bus.next_move, 15);
        chk("arst_busy", bus.busy, 0);
        chk("arst_moves", bus.moves_executed, 0);
        chk("arst_error", bus.error, 0);
        bus.run = 1'b0;
        @(posedge clk);
        #2 rst = 1'b0;
        clear_log();

        // abort during WAIT_DONE with 10 queued
        for (int i = 0; i < 11; i++) write(4'(3 + i));
        bus.run = 1'b1;
        wait_for(2, 20, "abort_start");
        wait_for(4, 20, "abort_busy");
        tick();
        chk("abort_pre_count", bus.fifo_count, 10);
        bus.abort = 1'b1; bus.move_wr = 1'b1; bus.move_in = 4'd9;
        tick();
        bus.abort = 1'b0; bus.move_wr = 1'b0;
        chk("abort_count", bus.fifo_count, 0);
        chk("abort_still_busy", bus.busy, 1);
        wait_for(1, 400, "abort_idle");
        chk("abort_seq_done", seq_cnt, 0);
        chk("abort_starts", starts.size(), 1);
        chk("abort_moves", bus.moves_executed, 1);

        // ack timeout
        bus.run = 1'b0;
        do_reset();
        stuck = 1;
        bus.run = 1'b1;
        write(4'd4); write(4'd5);
        wait_for(2, 20, "to_start");
        t1 = cyc;
        wait_for(3, ACK + 100, "to_error");
        chk("to_latency", cyc - t1, ACK + 1);
        repeat (300) tick();
        chk("to_starts", starts.size(), 1);
        chk("to_busy", bus.busy, 0);
        chk("to_count", bus.fifo_count, 1);
        chk("to_error", bus.error, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end
endmodule
